unidade_controle: RTL and testbench

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

---
 rtl/unidade_controle.sv | 238 +++++++++++++++++++++++
 tb/tb_unidade_controle.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle.sv
// Purpose : game-flow controller for the werewolf game; one FSM drives the datapath control strobes.
// Latency : outputs are decoded combinationally from the current state (plus a few status inputs); state moves on each rising clock edge.
// Backpressure: none; the FSM waits in the *_ESPERA / selection states until the user pulses confirmar or iniciar.
//
// Ports:
//   clock, reset                      - system clock, synchronous active-high reset
//   iniciar, confirmar                - single-cycle user pulses (already edge-detected)
//   CJ_fim, jogador_vivo, jogou,
//   votou, acertou, sinal_lobo_ganhou - datapath status
//   rst_global .. reset_Pular         - datapath control strobes
//   fim_jogo, lobo_venceu,
//   aldeoes_venceram                  - end-of-game indication
//   db_estado, db_rodada              - debug: state code and completed-night count
module unidade_controle (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       confirmar,
  input  logic       CJ_fim,
  input  logic       jogador_vivo,
  input  logic       jogou,
  input  logic       votou,
  input  logic       acertou,
  input  logic       sinal_lobo_ganhou,
  output logic       rst_global,
  output logic       zera_CS,
  output logic       inc_seed,
  output logic       e_seed_reg,
  output logic       zera_CJ,
  output logic       inc_jogador,
  output logic       mostra_classe,
  output logic       processar_acao,
  output logic       avaliar_eliminacao,
  output logic       voto,
  output logic       morra,
  output logic       reset_Pular,
  output logic       fim_jogo,
  output logic       lobo_venceu,
  output logic       aldeoes_venceram,
  output logic [4:0] db_estado,
  output logic [2:0] db_rodada
);

  typedef enum logic [4:0] {
    INICIAL        = 5'd0,
    ESCOLHE_SEED   = 5'd1,
    CARREGA_SEED   = 5'd2,
    MOSTRA         = 5'd3,
    PROX_MOSTRA    = 5'd4,
    NOITE_ESPERA   = 5'd5,
    NOITE_ACAO     = 5'd6,
    NOITE_CHECA    = 5'd7,
    NOITE_PROX     = 5'd8,
    AVALIA         = 5'd9,
    CHECA_NOITE    = 5'd10,
    DIA_ESPERA     = 5'd11,
    DIA_VOTO       = 5'd12,
    DIA_CHECA      = 5'd13,
    EXECUTA        = 5'd14,
    RESULTADO      = 5'd15,
    LOBO_VENCE     = 5'd16,
    ALDEOES_VENCEM = 5'd17
  } estado_t;

  estado_t    estado;
  estado_t    prox_estado;
  logic [2:0] rodada;
  logic       inc_rodada;

  // State and night counter. The counter is cleared whenever the FSM sits in
  // INICIAL so a new game always starts at night 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= INICIAL;
      rodada <= 3'd0;
    end else begin
      estado <= prox_estado;
      if (estado == INICIAL) begin
        rodada <= 3'd0;
      end else if (inc_rodada && (rodada != 3'd7)) begin
        rodada <= rodada + 3'd1;
      end
    end
  end

  always_comb begin
    prox_estado        = estado;
    inc_rodada         = 1'b0;
    rst_global         = 1'b0;
    zera_CS            = 1'b0;
    inc_seed           = 1'b0;
    e_seed_reg         = 1'b0;
    zera_CJ            = 1'b0;
    inc_jogador        = 1'b0;
    mostra_classe      = 1'b0;
    processar_acao     = 1'b0;
    avaliar_eliminacao = 1'b0;
    voto               = 1'b0;
    morra              = 1'b0;
    reset_Pular        = 1'b0;
    fim_jogo           = 1'b0;
    lobo_venceu        = 1'b0;
    aldeoes_venceram   = 1'b0;

    case (estado)
      INICIAL: begin
        rst_global = 1'b1;
        zera_CS    = 1'b1;
        zera_CJ    = 1'b1;
        if (iniciar) prox_estado = ESCOLHE_SEED;
      end

      // The seed counter spins while the user waits; the confirming cycle
      // freezes it so the loaded seed is exactly what was on display.
      ESCOLHE_SEED: begin
        if (confirmar) begin
          prox_estado = CARREGA_SEED;
        end else begin
          inc_seed = 1'b1;
        end
      end

      CARREGA_SEED: begin
        e_seed_reg  = 1'b1;
        zera_CJ     = 1'b1;
        prox_estado = MOSTRA;
      end

      MOSTRA: begin
        mostra_classe = 1'b1;
        if (confirmar) prox_estado = PROX_MOSTRA;
      end

      PROX_MOSTRA: begin
        if (CJ_fim) begin
          zera_CJ     = 1'b1;
          prox_estado = NOITE_ESPERA;
        end else begin
          inc_jogador = 1'b1;
          prox_estado = MOSTRA;
        end
      end

      // Dead players are skipped without waiting for the user.
      NOITE_ESPERA: begin
        if (!jogador_vivo) begin
          prox_estado = NOITE_PROX;
        end else if (confirmar) begin
          prox_estado = NOITE_ACAO;
        end
      end

      NOITE_ACAO: begin
        processar_acao = 1'b1;
        prox_estado    = NOITE_CHECA;
      end

      // An invalid action returns to the same player (no counter change).
      NOITE_CHECA: begin
        prox_estado = jogou ? NOITE_PROX : NOITE_ESPERA;
      end

      NOITE_PROX: begin
        if (CJ_fim) begin
          zera_CJ     = 1'b1;
          prox_estado = AVALIA;
        end else begin
          inc_jogador = 1'b1;
          prox_estado = NOITE_ESPERA;
        end
      end

      AVALIA: begin
        avaliar_eliminacao = 1'b1;
        prox_estado        = CHECA_NOITE;
      end

      CHECA_NOITE: begin
        prox_estado = sinal_lobo_ganhou ? LOBO_VENCE : DIA_ESPERA;
      end

      DIA_ESPERA: begin
        if (confirmar) prox_estado = DIA_VOTO;
      end

      DIA_VOTO: begin
        voto        = 1'b1;
        prox_estado = DIA_CHECA;
      end

      // votou low means the chosen target was already dead: vote again.
      DIA_CHECA: begin
        prox_estado = votou ? EXECUTA : DIA_ESPERA;
      end

      EXECUTA: begin
        morra       = 1'b1;
        prox_estado = RESULTADO;
      end

      // Catching the wolf wins for the villagers even if the wolf count
      // condition is also met in the same cycle.
      RESULTADO: begin
        if (acertou) begin
          prox_estado = ALDEOES_VENCEM;
        end else if (sinal_lobo_ganhou) begin
          prox_estado = LOBO_VENCE;
        end else begin
          reset_Pular = 1'b1;
          zera_CJ     = 1'b1;
          inc_rodada  = 1'b1;
          prox_estado = NOITE_ESPERA;
        end
      end

      LOBO_VENCE: begin
        fim_jogo    = 1'b1;
        lobo_venceu = 1'b1;
        if (iniciar) prox_estado = INICIAL;
      end

      ALDEOES_VENCEM: begin
        fim_jogo         = 1'b1;
        aldeoes_venceram = 1'b1;
        if (iniciar) prox_estado = INICIAL;
      end

      // Codes 18-31 recover to INICIAL with all outputs low.
      default: begin
        prox_estado = INICIAL;
      end
    endcase
  end

  assign db_estado = estado;
  assign db_rodada = rodada;

endmodule

// File: tb/tb_unidade_controle.sv
module tb_unidade_controle;

  logic       clock = 1'b0;
  logic       reset, iniciar, confirmar, CJ_fim, jogador_vivo, jogou, votou, acertou, sinal_lobo_ganhou;
  logic       rst_global, zera_CS, inc_seed, e_seed_reg, zera_CJ, inc_jogador, mostra_classe;
  logic       processar_acao, avaliar_eliminacao, voto, morra, reset_Pular;
  logic       fim_jogo, lobo_venceu, aldeoes_venceram;
  logic [4:0] db_estado;
  logic [2:0] db_rodada;

  always #5 clock = ~clock;

  unidade_controle dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .confirmar(confirmar),
    .CJ_fim(CJ_fim), .jogador_vivo(jogador_vivo), .jogou(jogou), .votou(votou),
    .acertou(acertou), .sinal_lobo_ganhou(sinal_lobo_ganhou),
    .rst_global(rst_global), .zera_CS(zera_CS), .inc_seed(inc_seed), .e_seed_reg(e_seed_reg),
    .zera_CJ(zera_CJ), .inc_jogador(inc_jogador), .mostra_classe(mostra_classe),
    .processar_acao(processar_acao), .avaliar_eliminacao(avaliar_eliminacao), .voto(voto),
    .morra(morra), .reset_Pular(reset_Pular), .fim_jogo(fim_jogo), .lobo_venceu(lobo_venceu),
    .aldeoes_venceram(aldeoes_venceram), .db_estado(db_estado), .db_rodada(db_rodada)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: game phase as a plain integer taken from the state list,
  // and the night count as an integer.
  localparam int INI = 0, ESC = 1, CAR = 2, MOS = 3, PMO = 4, NES = 5, NAC = 6, NCH = 7,
                 NPR = 8, AVA = 9, CNO = 10, DES = 11, DVO = 12, DCH = 13, EXE = 14,
                 RES = 15, LOB = 16, ALD = 17;
  int m_st = 0;
  int m_rod = 0;

  // Expected output set, one bit per signal in the order:
  // rst_global zera_CS inc_seed e_seed_reg zera_CJ inc_jogador mostra_classe
  // processar_acao avaliar_eliminacao voto morra reset_Pular fim lobo aldeoes
  function automatic logic [14:0] expected_out(int s, bit conf, bit cjf, bit ace, bit lob);
    logic [14:0] o;
    o = '0;
    if (s == INI) begin o[14] = 1; o[13] = 1; o[10] = 1; end
    if (s == ESC && !conf) o[12] = 1;
    if (s == CAR) begin o[11] = 1; o[10] = 1; end
    if (s == MOS) o[8] = 1;
    if (s == PMO || s == NPR) begin
      if (cjf) o[10] = 1; else o[9] = 1;
    end
    if (s == NAC) o[7] = 1;
    if (s == AVA) o[6] = 1;
    if (s == DVO) o[5] = 1;
    if (s == EXE) o[4] = 1;
    if (s == RES && !ace && !lob) begin o[3] = 1; o[10] = 1; end
    if (s == LOB) begin o[2] = 1; o[1] = 1; end
    if (s == ALD) begin o[2] = 1; o[0] = 1; end
    return o;
  endfunction

  function automatic int next_phase(int s, bit ini, bit conf, bit cjf, bit viv, bit jog,
                                    bit vot, bit ace, bit lob);
    if (s == INI) return ini ? ESC : INI;
    if (s == ESC) return conf ? CAR : ESC;
    if (s == CAR) return MOS;
    if (s == MOS) return conf ? PMO : MOS;
    if (s == PMO) return cjf ? NES : MOS;
    if (s == NES) return !viv ? NPR : (conf ? NAC : NES);
    if (s == NAC) return NCH;
    if (s == NCH) return jog ? NPR : NES;
    if (s == NPR) return cjf ? AVA : NES;
    if (s == AVA) return CNO;
    if (s == CNO) return lob ? LOB : DES;
    if (s == DES) return conf ? DVO : DES;
    if (s == DVO) return DCH;
    if (s == DCH) return vot ? EXE : DES;
    if (s == EXE) return RES;
    if (s == RES) return ace ? ALD : (lob ? LOB : NES);
    if (s == LOB || s == ALD) return ini ? INI : s;
    return INI;
  endfunction

  int c_inc_seed, c_e_seed, c_inc_jog, c_zera_cj, c_proc, c_aval, c_voto, c_morra, c_rpular;

  task automatic clr_counts();
    c_inc_seed = 0; c_e_seed = 0; c_inc_jog = 0; c_zera_cj = 0; c_proc = 0;
    c_aval = 0; c_voto = 0; c_morra = 0; c_rpular = 0;
  endtask

  // One clock cycle: drive inputs at the falling edge, compare every output
  // with the model, then advance both across the rising edge.
  task automatic cyc(input bit rst, input bit ini, input bit conf, input bit cjf, input bit viv,
                     input bit jog, input bit vot, input bit ace, input bit lob);
    logic [14:0] got;
    reset = rst; iniciar = ini; confirmar = conf; CJ_fim = cjf; jogador_vivo = viv;
    jogou = jog; votou = vot; acertou = ace; sinal_lobo_ganhou = lob;
    #1;
    got = {rst_global, zera_CS, inc_seed, e_seed_reg, zera_CJ, inc_jogador, mostra_classe,
           processar_acao, avaliar_eliminacao, voto, morra, reset_Pular,
           fim_jogo, lobo_venceu, aldeoes_venceram};
    check("outputs", got, expected_out(m_st, conf, cjf, ace, lob));
    check("db_estado", db_estado, m_st);
    check("db_rodada", db_rodada, m_rod);
    c_inc_seed += int'(inc_seed); c_e_seed += int'(e_seed_reg); c_inc_jog += int'(inc_jogador);
    c_zera_cj += int'(zera_CJ); c_proc += int'(processar_acao); c_aval += int'(avaliar_eliminacao);
    c_voto += int'(voto); c_morra += int'(morra); c_rpular += int'(reset_Pular);
    @(posedge clock);
    if (rst) begin
      m_st = INI; m_rod = 0;
    end else begin
      if (m_st == INI) m_rod = 0;
      else if (m_st == RES && !ace && !lob && m_rod < 7) m_rod++;
      m_st = next_phase(m_st, ini, conf, cjf, viv, jog, vot, ace, lob);
    end
    @(negedge clock);
  endtask

  // From INICIAL through seed and a one-player class display into the night.
  task automatic to_night();
    cyc(0,1,0,0,1,0,0,0,0);
    cyc(0,0,1,0,1,0,0,0,0);
    cyc(0,0,0,0,1,0,0,0,0);
    cyc(0,0,1,0,1,0,0,0,0);
    cyc(0,0,0,1,1,0,0,0,0);
  endtask

  // One full night+day from NOITE_ESPERA with a single dead player and no winner.
  task automatic round_no_winner();
    cyc(0,0,0,0,0,0,0,0,0);
    cyc(0,0,0,1,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0,0);
    cyc(0,0,1,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,1,0,0);
    cyc(0,0,0,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0,0);
  endtask

  initial begin
    reset = 1; iniciar = 0; confirmar = 0; CJ_fim = 0; jogador_vivo = 0;
    jogou = 0; votou = 0; acertou = 0; sinal_lobo_ganhou = 0;
    @(posedge clock);
    @(negedge clock);
    m_st = INI; m_rod = 0;
    clr_counts();

    // Reset state, then seed selection with 3 idle cycles.
    cyc(0,0,0,0,0,0,0,0,0);
    cyc(0,0,1,0,0,0,0,0,0);           // confirmar ignored in INICIAL
    check("inicial_hold", db_estado, 0);
    cyc(0,1,0,0,0,0,0,0,0);
    clr_counts();
    for (int i = 0; i < 3; i++) cyc(0,0,0,0,0,0,0,0,0);
    cyc(0,0,1,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0,0);
    check("seed_inc_count", c_inc_seed, 3);
    check("seed_load_count", c_e_seed, 1);
    check("after_seed_state", db_estado, 3);

    // Class display for 5 players.
    clr_counts();
    for (int i = 0; i < 5; i++) begin
      cyc(0,0,1,0,0,0,0,0,0);
      cyc(0,0,0,(i == 4),0,0,0,0,0);
    end
    check("show_inc_jog", c_inc_jog, 4);
    check("show_zera_cj", c_zera_cj, 1);
    check("night_entry", db_estado, 5);

    // Night: player 1 retries once, player 2 dead and skipped.
    clr_counts();
    cyc(0,0,1,0,1,0,0,0,0);
    cyc(0,0,0,0,1,0,0,0,0);
    cyc(0,0,0,0,1,0,0,0,0);           // jogou=0 -> retry
    cyc(0,0,1,0,1,0,0,0,0);
    cyc(0,0,0,0,1,0,0,0,0);
    cyc(0,0,0,0,1,1,0,0,0);
    cyc(0,0,0,0,1,0,0,0,0);           // next player
    cyc(0,0,0,0,0,0,0,0,0);           // dead, no confirmar needed
    cyc(0,0,0,1,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0,0);
    check("night_proc", c_proc, 2);
    check("night_aval", c_aval, 1);
    check("night_inc_jog", c_inc_jog, 1);
    cyc(0,0,0,0,0,0,0,0,0);
    check("day_entry", db_estado, 11);

    // Day: first vote on a dead target, second hits the wolf; acertou beats sinal_lobo_ganhou.
    clr_counts();
    cyc(0,0,1,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0,0);
    cyc(0,0,1,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,1,0,0);
    cyc(0,0,0,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,1,1);
    check("day_voto", c_voto, 2);
    check("day_morra", c_morra, 1);
    check("ald_state", db_estado, 17);
    check("ald_fim", fim_jogo, 1);
    check("ald_flag", aldeoes_venceram, 1);
    cyc(0,0,1,0,0,0,0,0,0);           // confirmar ignored
    check("ald_hold", db_estado, 17);
    cyc(0,1,0,0,0,0,0,0,0);

    // Eight rounds without a winner: night count saturates at 7.
    to_night();
    clr_counts();
    for (int k = 1; k <= 8; k++) begin
      round_no_winner();
      check("rodada", db_rodada, (k > 7) ? 7 : k);
    end
    check("rpular_count", c_rpular, 8);
    cyc(0,0,0,0,0,0,0,0,0);
    cyc(0,0,0,1,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0,1);
    check("lobo_state", db_estado, 16);
    check("lobo_flag", lobo_venceu, 1);
    cyc(0,1,0,0,0,0,0,0,0);
    check("restart_clears_rodada", db_rodada, 7);
    cyc(0,0,0,0,0,0,0,0,0);
    check("rodada_cleared", db_rodada, 0);

    // Reset in the middle of a night action check.
    to_night();
    round_no_winner();
    cyc(0,0,1,0,1,0,0,0,0);
    cyc(0,0,0,0,1,0,0,0,0);
    check("pre_reset_state", db_estado, 7);
    cyc(1,0,0,0,1,1,0,0,0);
    check("rst_estado", db_estado, 0);
    check("rst_rodada", db_rodada, 0);
    check("rst_global", rst_global, 1);

    // Random play against the model.
    for (int n = 0; n < 4000; n++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 4) != 0),
          ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
